ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Sync FIFO controller sitting directly upstream/downstream of the 8x4 register RAM.
//  Accepts a valid/ready push stream and drives the RAM write port.
//  Issues RAM reads, captures the 1-cycle-latency read data into an output register,
//  and presents it as a valid/ready pop stream. The RAM sits outside this block.
// PARAMETERS
//  DW      4  data width (matches RAM word)
//  DEPTH   8  RAM entries used; power of two
//  AW      3  pointer width = log2(DEPTH)
//  RAM_AW  8  RAM address port width; upper bits driven 0
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  in_valid        in   1       push request
//  in_ready        out  1       push accepted when in_valid&&in_ready
//  in_data         in   DW      push data
//  out_valid       out  1       out_data valid
//  out_ready       in   1       pop when out_valid&&out_ready
//  out_data        out  DW      head-of-FIFO data
//  count           out  AW+1    total items held: RAM + in-flight + output reg
//  ram_write_en    out  1       to RAM write_en
//  ram_write_addr  out  RAM_AW  to RAM write_addr = {0, wr_ptr}
//  ram_write_data  out  DW      to RAM write_data
//  ram_read_en     out  1       to RAM read_en
//  ram_read_addr   out  RAM_AW  to RAM read_addr = {0, rd_ptr}
//  ram_read_data   in   DW      from RAM read_data; valid 1 cycle after read_en, else 0
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, out_data=0, count=0, wr_ptr=rd_ptr=0,
//   mem_cnt=0, state=IDLE. While rst_n=0, ram_write_en=0 and ram_read_en=0.
//  Push:
//   - push = in_valid && in_ready; in_ready = (count < DEPTH), combinational.
//   - ram_write_en = push; ram_write_data = in_data.
//   - wr_ptr += 1 mod DEPTH on push.
//  mem_cnt: items resident in RAM, not yet read. +1 on push, -1 on read issue; both at once -> unchanged.
//  FSM (out path holds at most 1 item):
//   - IDLE:  out_valid=0. If mem_cnt>0 -> ram_read_en=1, rd_ptr+=1, go FETCH.
//   - FETCH: out_valid=0, ram_read_en=0. At next edge out_data<=ram_read_data, go HOLD.
//   - HOLD:  out_valid=1; out_data held stable until popped.
//            Pop && mem_cnt>0 -> issue read (same rules as IDLE), go FETCH.
//            Pop && mem_cnt==0 -> IDLE. No pop -> stay HOLD.
//  Read issue uses registered mem_cnt only. A push in the same cycle is not readable
//   until the next cycle, so read and write never target one address in the same cycle.
//  Latency: push accepted at edge E -> out_valid=1 after edge E+2 (empty FIFO).
//  Throughput: 1 pop per 2 cycles max; 1 push per cycle until full.
//  count = mem_cnt + (state==FETCH) + out_valid. Updated every edge; range 0..DEPTH.
//  Boundaries:
//   - Full (count==DEPTH): in_ready=0; push ignored, ram_write_en=0.
//   - Pop at full: in_ready rises the next cycle; not combinationally from out_ready.
//   - Empty: out_valid=0; out_ready ignored.
//   - Pointer wrap: DEPTH-1 -> 0, no gap or duplicate.
//   - Reset mid-operation (any state): everything returns to reset values.
//     In-flight read data is discarded.
//  Arithmetic: pointers mod 2^AW; count/mem_cnt never over/underflow by construction.
// TESTING
//  1. Assert rst_n=0 -> in_ready=1, out_valid=0, out_data=0, count=0, ram_*_en=0.
//  2. Push 0x3,0xA,0x5 back-to-back, out_ready=1 -> pops 0x3,0xA,0x5 in order;
//     first out_valid 2 cycles after first push; count returns to 0.
//  3. out_ready=0, push 10 items 0x1..0xA -> in_ready=0 after 8 accepted, count=8,
//     out_data=0x1 stable; drain gives 0x1..0x8.
//  4. Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data unchanged;
//     release -> next item appears 2 cycles later.
//  5. Wrap: stream 20 items (i mod 16) with random out_ready -> exact order,
//     ram_write_addr/ram_read_addr cycle 0..7, count never > 8.
//  6. Pulse rst_n low while state=FETCH with 3 items held -> count=0, out_valid=0;
//     next push of 0x7 pops as 0x7.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller around an external 1-cycle-latency register RAM
module ram_fifo_ctrl #(
    parameter int DW     = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [AW:0]       count,
    output logic              ram_write_en,
    output logic [RAM_AW-1:0] ram_write_addr,
    output logic [DW-1:0]     ram_write_data,
    output logic              ram_read_en,
    output logic [RAM_AW-1:0] ram_read_addr,
    input  logic [DW-1:0]     ram_read_data
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] mem_cnt;
    logic push, pop, rd_issue;
    assign count     = mem_cnt + (AW+1)'(state == FETCH) + (AW+1)'(out_valid);
    assign in_ready  = count < (AW+1)'(DEPTH);
    assign push      = rst_n && in_valid && in_ready;
    assign out_valid = state == HOLD;
    assign pop       = out_valid && out_ready;
    // only RAM-resident items are readable, so a same-cycle push never collides with the read
    assign rd_issue  = mem_cnt != '0 && (state == IDLE || pop);
    assign ram_write_en   = push;
    assign ram_write_addr = {{(RAM_AW-AW){1'b0}}, wr_ptr};
    assign ram_write_data = in_data;
    assign ram_read_en    = rd_issue;
    assign ram_read_addr  = {{(RAM_AW-AW){1'b0}}, rd_ptr};
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rd_issue ? FETCH : IDLE;
            FETCH:   state_nxt = HOLD;
            HOLD:    state_nxt = !pop ? HOLD : rd_issue ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            out_data <= '0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(rd_issue);
            mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(rd_issue);
            if (state == FETCH)
                out_data <= ram_read_data;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a behavioural 8x4 RAM
module tb_ram_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [3:0] count;
    logic       ram_write_en, ram_read_en;
    logic [7:0] ram_write_addr, ram_read_addr;
    logic [3:0] ram_write_data;
    logic [3:0] ram_read_data = '0;
    logic [3:0] mem [256];
    logic [3:0] q [$];
    logic [2:0] wp = '0, rp = '0;
    int n_checks = 0, n_errors = 0;

    ram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
        .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= ram_read_en ? mem[ram_read_addr] : 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: push on accepted input, pop/compare on accepted output, address model alongside
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            wp = '0;
            rp = '0;
            check("rst_wen", ram_write_en, 0);
            check("rst_ren", ram_read_en, 0);
            check("rst_count", count, 0);
        end else begin
            check("count", count, q.size());
            check("count_max", count > 8, 0);
            check("in_ready", in_ready, q.size() < 8);
            if (q.size() == 0) check("empty_valid", out_valid, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("pop_underflow", q.size(), 1);
                else check("pop_data", out_data, q.pop_front());
            end
            if (ram_read_en) begin
                check("rd_addr", ram_read_addr, {5'b0, rp});
                rp++;
            end
            if (in_valid && in_ready) begin
                check("wr_en", ram_write_en, 1);
                check("wr_addr", ram_write_addr, {5'b0, wp});
                check("wr_data", ram_write_data, in_data);
                q.push_back(in_data);
                wp++;
            end else begin
                check("wr_idle", ram_write_en, 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        out_ready = 1'b1;
        for (n = 0; n < budget && q.size() != 0; n++) cyc();
        cyc();
        check("drain", q.size(), 0);
        check("drain_count", count, 0);
        check("drain_valid", out_valid, 0);
    endtask

    task automatic push_seq(input logic [3:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = first + 4'(i);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        logic acc;
        in_valid = 1'b1;
        in_data = 4'h9;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count0", count, 0);
        check("rst_wen0", ram_write_en, 0);
        check("rst_ren0", ram_read_en, 0);
        repeat (2) cyc();
        in_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // back-to-back pushes with immediate pops, first-output latency
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 4'h3;
        cyc();
        check("lat_e0", out_valid, 0);
        in_data = 4'hA;
        cyc();
        check("lat_e1", out_valid, 0);
        in_data = 4'h5;
        cyc();
        check("lat_e2", out_valid, 1);
        check("lat_data", out_data, 4'h3);
        in_valid = 1'b0;
        drain(20);

        // fill past full with no pops
        out_ready = 1'b0;
        push_seq(4'h1, 10);
        cyc();
        check("full_count", count, 8);
        check("full_ready", in_ready, 0);
        check("full_head", out_data, 4'h1);
        out_ready = 1'b1;
        #1;
        check("full_ready_comb", in_ready, 0);
        cyc();
        check("full_ready_next", in_ready, 1);
        drain(40);

        // backpressure: output held stable, then 2-cycle refill after release
        out_ready = 1'b0;
        push_seq(4'hC, 3);
        repeat (2) cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 4'hC);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("bp_gap", out_valid, 0);
        cyc();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_data", out_data, 4'hD);
        drain(20);

        // wrap: 20 items with random backpressure
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = 4'(i);
            budget = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = in_ready;
                cyc();
                budget++;
            end while (!acc && budget < 50);
            check("wrap_accept", acc, 1);
        end
        in_valid = 1'b0;
        drain(60);

        // reset while a read is in flight with 3 items held
        out_ready = 1'b0;
        push_seq(4'h4, 4);
        repeat (2) cyc();
        check("pre_pop_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("pre_rst_count", count, 3);
        check("pre_rst_fetch", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ready", in_ready, 1);
        repeat (2) cyc();
        check("post_rst_data", out_data, 0);
        rst_n = 1'b1;
        cyc();
        push_seq(4'h7, 1);
        repeat (2) cyc();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_pop", out_data, 4'h7);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
